// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter sharing one bus among eight masters; grant held until done/req drop.
// Latency: grant registered on the edge req is seen in IDLE; one idle turnaround cycle after every release.
// Backpressure: none; optional forced release after MAX_HOLD cycles when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state, state_nxt;
    logic [7:0] grant_nxt;
    logic [2:0] idx_nxt;
    logic [2:0] last_owner, last_nxt;
    logic [2:0] cand, winner;
    logic       busy_nxt, preempt_nxt;
    logic       found, timeout, rel;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter_8: MAX_HOLD must be in 2..255");
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt, hold_nxt;
`endif

    // Rotating priority: scan starts just after the most recent winner.
    always_comb begin
        found  = 1'b0;
        winner = last_owner;
        cand   = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_owner + 3'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        busy_nxt    = busy;
        preempt_nxt = 1'b0;
        last_nxt    = last_owner;
        timeout     = 1'b0;
        rel         = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        hold_nxt    = hold_cnt;
        timeout     = (hold_cnt == HOLD_LAST);
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWN;
                    grant_nxt = 8'h01 << winner;
                    idx_nxt   = winner;
                    last_nxt  = winner;
                    busy_nxt  = 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            OWN: begin
                rel = done || !req[grant_idx] || timeout;
                if (rel) begin
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    busy_nxt    = 1'b0;
                    // A voluntary release on the same edge wins over the timeout.
                    preempt_nxt = timeout && !done && req[grant_idx];
                end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                    if (hold_cnt != 8'hFF) hold_nxt = hold_cnt + 8'd1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            busy       <= 1'b0;
            preempt    <= 1'b0;
            last_owner <= 3'd7;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            grant_idx  <= idx_nxt;
            busy       <= busy_nxt;
            preempt    <= preempt_nxt;
            last_owner <= last_nxt;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt <= '0;
        else        hold_cnt <= hold_nxt;
    end
`endif

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Bench for bus_arbiter_8: directed vector table, hand sequences and a random run against a reference model.
module tb_bus_arbiter_8;

    localparam int MAX_HOLD = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 when idle), last winner, cycles granted so far.
    int m_owner, m_last, m_hold;
    bit m_pre;

    bus_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        int c;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
                c = (m_last + k) % 8;
                if (r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (d || !r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_hold >= MAX_HOLD) begin
            m_owner = -1;
            m_pre   = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    function automatic logic [7:0] m_grant();
        return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    endfunction

    task automatic cycle(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        chk("grant", 32'(grant), 32'(m_grant()));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("preempt", 32'(preempt), 32'(m_pre));
        if (m_owner >= 0) chk("grant_idx", 32'(grant_idx), 32'(m_owner));
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        req   = r;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rr;
        logic [7:0] exp_g;

        tbl[0]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
        tbl[1]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1};
        tbl[3]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[5]  = '{8'h20, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{8'h09, 1'b0, 8'h01, 3'd0, 1'b1};
        tbl[7]  = '{8'h09, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{8'h09, 1'b0, 8'h08, 3'd3, 1'b1};
        tbl[9]  = '{8'h01, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[10] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1};
        tbl[11] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[12] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[13] = '{8'h40, 1'b0, 8'h40, 3'd6, 1'b1};

        // Reset priority, wrap-around skip and owner drop
        do_reset(8'h81);
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].req, tbl[i].done);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_preempt", i), 32'(preempt), 32'h0);
            if (tbl[i].busy) chk($sformatf("tbl%0d_idx", i), 32'(grant_idx), 32'(tbl[i].idx));
        end

        // Rotation with all requesters active
        do_reset(8'hFF);
        for (int i = 0; i < 9; i++) begin
            exp_g = 8'h01 << (i % 8);
            cycle(8'hFF, 1'b0);
            chk("rot_grant", 32'(grant), 32'(exp_g));
            cycle(8'hFF, 1'b1);
            chk("rot_gap", 32'(grant), 32'h0);
        end

        // Long hold: forced release with the timeout, unbounded without it
        do_reset(8'h00);
        cycle(8'h10, 1'b0);
        chk("hold_first", 32'(grant), 32'h10);
        if (TO_EN) begin
            for (int i = 0; i < MAX_HOLD - 1; i++) begin
                cycle(8'h10, 1'b0);
                chk("hold_grant", 32'(grant), 32'h10);
            end
            cycle(8'h10, 1'b0);
            chk("to_grant", 32'(grant), 32'h0);
            chk("to_preempt", 32'(preempt), 32'h1);
            cycle(8'h10, 1'b0);
            chk("to_regrant", 32'(grant), 32'h10);
            chk("to_preempt_end", 32'(preempt), 32'h0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                cycle(8'h10, 1'b0);
                chk("hold_grant", 32'(grant), 32'h10);
                chk("hold_preempt", 32'(preempt), 32'h0);
            end
        end

        // Asynchronous reset in the middle of a grant
        do_reset(8'h00);
        cycle(8'h20, 1'b0);
        chk("mid_grant", 32'(grant), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        model_reset();
        req = 8'h21;
        #2;
        rst_n = 1'b1;
        cycle(8'h21, 1'b0);
        chk("post_rst_grant", 32'(grant), 32'h01);

        // Random traffic with sticky request lines
        do_reset(8'h00);
        rr = '0;
        for (int i = 0; i < 3000; i++) begin
            rr = rr ^ 8'($urandom & $urandom & $urandom);
            cycle(rr, ($urandom_range(0, 5) == 0));
            chk("onehot", 32'($countones(grant) <= 1), 32'h1);
            chk("busy_vs_grant", 32'(busy), 32'(|grant));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
